// File: rtl/bemicro_cv_sys_irq_ctrl.sv
// rtl/bemicro_cv_sys_irq_ctrl.sv - interrupt aggregator with level/edge capture, masking and priority vector
//
// Purpose: latches NUM_IRQ peripheral interrupt requests (each level- or
// edge-qualified), masks them and drives one registered irq to the CPU.
// A VECTOR register returns the lowest-numbered pending+enabled source.
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   irq_in     peripheral requests, bit 0 is the system timer
//   address    register word address (0..7)
//   chipselect slave select
//   write_n    active-low write strobe, qualified by chipselect
//   writedata  16-bit write data
//   readdata   registered read data (1-cycle latency)
//   irq        registered interrupt request, |(pending & enable)

`timescale 1ns/1ps

module bemicro_cv_sys_irq_ctrl #(
    parameter int NUM_IRQ = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    output logic               irq
);

    localparam logic [2:0] A_PENDING = 3'd0;
    localparam logic [2:0] A_ENABLE  = 3'd1;
    localparam logic [2:0] A_MODE    = 3'd2;
    localparam logic [2:0] A_VECTOR  = 3'd3;
    localparam logic [2:0] A_OVERRUN = 3'd4;
    localparam logic [2:0] A_SWTRIG  = 3'd5;
    localparam logic [2:0] A_RAW     = 3'd6;

    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] enable_q,  enable_d;
    logic [NUM_IRQ-1:0] mode_q,    mode_d;
    logic [NUM_IRQ-1:0] overrun_q, overrun_d;
    logic [NUM_IRQ-1:0] irq_d_q,   irq_d_d;
    logic [15:0]        readdata_q, readdata_d;
    logic               irq_q,     irq_d;

    logic               wr;
    logic [NUM_IRQ-1:0] wdata;
    logic [NUM_IRQ-1:0] active;
    logic [NUM_IRQ-1:0] edge_ev;
    logic [NUM_IRQ-1:0] hw_set;
    logic [NUM_IRQ-1:0] sw_set;
    logic [NUM_IRQ-1:0] pend_clr;
    logic [NUM_IRQ-1:0] ovr_set;
    logic [NUM_IRQ-1:0] ovr_clr;
    logic               vec_valid;
    logic [3:0]         vec_idx;
    logic [NUM_IRQ-1:0] vec_onehot;
    logic               unused_wd;

    assign wr        = chipselect & ~write_n;
    assign wdata     = writedata[NUM_IRQ-1:0];
    assign active    = pending_q & enable_q;
    // Folds every writedata bit so the unused upper bits stay visibly consumed.
    assign unused_wd = ^writedata;

    // Lowest-index priority encoder over pending & enable.
    always_comb begin
        vec_valid  = 1'b0;
        vec_idx    = 4'd0;
        vec_onehot = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (active[i] && !vec_valid) begin
                vec_valid     = 1'b1;
                vec_idx       = 4'(i);
                vec_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        edge_ev  = irq_in & ~irq_d_q;
        hw_set   = (mode_q & edge_ev) | (~mode_q & irq_in);
        sw_set   = (wr && address == A_SWTRIG) ? wdata : '0;
        pend_clr = ((wr && address == A_PENDING) ? wdata : '0)
                 | ((wr && address == A_VECTOR)  ? vec_onehot : '0);
        // Only an edge-mode hardware event on an already-pending source overruns.
        ovr_set  = mode_q & edge_ev & pending_q;
        ovr_clr  = (wr && address == A_OVERRUN) ? wdata : '0;

        // Set terms are ORed in after the clear so set wins on the same bit.
        pending_d = (pending_q & ~pend_clr) | hw_set | sw_set;
        overrun_d = (overrun_q & ~ovr_clr) | ovr_set;
        enable_d  = (wr && address == A_ENABLE) ? wdata : enable_q;
        mode_d    = (wr && address == A_MODE)   ? wdata : mode_q;
        irq_d_d   = irq_in;
        irq_d     = |active;
    end

    // Read mux samples pre-write register values every cycle.
    always_comb begin
        readdata_d = 16'h0000;
        case (address)
            A_PENDING: readdata_d = 16'(pending_q);
            A_ENABLE:  readdata_d = 16'(enable_q);
            A_MODE:    readdata_d = 16'(mode_q);
            A_VECTOR:  readdata_d = vec_valid ? {1'b1, 11'b0, vec_idx} : 16'h0000;
            A_OVERRUN: readdata_d = 16'(overrun_q);
            A_RAW:     readdata_d = 16'(irq_in);
            default:   readdata_d = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q  <= '0;
            enable_q   <= '0;
            mode_q     <= '0;
            overrun_q  <= '0;
            irq_d_q    <= '0;
            readdata_q <= 16'h0000;
            irq_q      <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            enable_q   <= enable_d;
            mode_q     <= mode_d;
            overrun_q  <= overrun_d;
            irq_d_q    <= irq_d_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule
